// File: rtl/booth_r4_multiplier.sv
// Radix-4 (modified Booth) sequential multiplier.
// Retires two multiplier bits per cycle over STEPS = WIDTH/2+1 iterations.
// Both operands are extended to WIDTH+2 bits, so the same datapath handles
// signed and unsigned operands. The accumulator is WIDTH+3 bits wide so
// that +/-2M never overflows it.
module booth_r4_multiplier #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic               op_signed,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic               op_busy,
  output logic               op_done,
  output logic [2*WIDTH-1:0] result
);

  localparam int STEPS = WIDTH / 2 + 1;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam int XW    = WIDTH + 2;
  localparam int AW    = WIDTH + 3;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic signed [AW-1:0]   r_acc;
  logic        [XW-1:0]   r_q;
  logic                   r_q1;
  logic signed [XW-1:0]   r_m;
  logic [CNT_W-1:0]       r_cnt;
  logic [2*WIDTH-1:0]     r_result;

  logic                   w_last;
  logic        [2:0]      w_dig;
  logic signed [AW-1:0]   w_m1;
  logic signed [AW-1:0]   w_m2;
  logic signed [AW-1:0]   w_addend;
  logic                   w_cin;
  logic        [AW-1:0]   w_sum;
  logic signed [AW-1:0]   w_acc_nx;
  logic        [XW-1:0]   w_q_nx;
  logic [2*WIDTH-1:0]     w_prod;

  // Widen an operand to WIDTH+2 bits; sign bit replicated only in signed mode.
  function automatic logic [XW-1:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
    return {{2{sgn & v[WIDTH-1]}}, v};
  endfunction

  assign w_last = (r_cnt == CNT_W'(1));
  assign w_dig  = {r_q[1:0], r_q1};
  assign w_m1   = {r_m[XW-1], r_m};
  assign w_m2   = {r_m, 1'b0};

  // Booth digit recoding: negative digits use inverted addend plus carry-in.
  always_comb begin
    w_addend = '0;
    w_cin    = 1'b0;
    case (w_dig)
      3'b001, 3'b010: w_addend = w_m1;
      3'b011:         w_addend = w_m2;
      3'b100: begin
        w_addend = ~w_m2;
        w_cin    = 1'b1;
      end
      3'b101, 3'b110: begin
        w_addend = ~w_m1;
        w_cin    = 1'b1;
      end
      default: begin
        w_addend = '0;
        w_cin    = 1'b0;
      end
    endcase
  end

  // Partial-product accumulate, then arithmetic shift of {acc,q,q_1} by two.
  assign w_sum    = r_acc + w_addend + {{(AW-1){1'b0}}, w_cin};
  assign w_acc_nx = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
  assign w_q_nx   = {w_sum[1:0], r_q[XW-1:2]};
  assign w_prod   = {w_acc_nx[WIDTH-3:0], w_q_nx};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: clear aborts anything; start only honoured in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (op_start) w_next = S_CALC;
      S_CALC:  if (w_last)   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (op_clear) w_next = S_IDLE;
  end

  // Operand latch, iteration datapath and result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_q      <= '0;
      r_q1     <= 1'b0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (op_clear) begin
      r_acc    <= '0;
      r_q      <= '0;
      r_q1     <= 1'b0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (op_start) begin
            r_m   <= extend(multiplicand, op_signed);
            r_q   <= extend(multiplier, op_signed);
            r_acc <= '0;
            r_q1  <= 1'b0;
            r_cnt <= CNT_W'(STEPS);
          end
        end
        S_CALC: begin
          r_acc <= w_acc_nx;
          r_q   <= w_q_nx;
          r_q1  <= r_q[1];
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) r_result <= w_prod;
        end
        default: ;
      endcase
    end
  end

  assign op_busy = (r_state != S_IDLE);
  assign op_done = (r_state == S_DONE);
  assign result  = r_result;

endmodule

// File: tb/tb_booth_r4_multiplier.sv
module tb_booth_r4_multiplier;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic s8, c8, g8, s16, c16, g16, s64, c64, g64;
  logic [7:0]   a8,  b8;
  logic [15:0]  a16, b16;
  logic [63:0]  a64, b64;
  logic         busy8, done8, busy16, done16, busy64, done64;
  logic [15:0]  res8;
  logic [31:0]  res16;
  logic [127:0] res64;

  int checks = 0;
  int errors = 0;

  booth_r4_multiplier #(.WIDTH(8)) u8 (
    .clk(clk), .reset(rst), .op_start(s8), .op_clear(c8), .op_signed(g8),
    .multiplier(b8), .multiplicand(a8), .op_busy(busy8), .op_done(done8), .result(res8));
  booth_r4_multiplier #(.WIDTH(16)) u16 (
    .clk(clk), .reset(rst), .op_start(s16), .op_clear(c16), .op_signed(g16),
    .multiplier(b16), .multiplicand(a16), .op_busy(busy16), .op_done(done16), .result(res16));
  booth_r4_multiplier #(.WIDTH(64)) u64 (
    .clk(clk), .reset(rst), .op_start(s64), .op_clear(c64), .op_signed(g64),
    .multiplier(b64), .multiplicand(a64), .op_busy(busy64), .op_done(done64), .result(res64));

  task automatic drv(input int w, input logic st, input logic cl, input logic sg,
                     input logic [63:0] a, input logic [63:0] b);
    case (w)
      8:  begin s8 = st;  c8 = cl;  g8 = sg;  a8 = a[7:0];   b8 = b[7:0];   end
      16: begin s16 = st; c16 = cl; g16 = sg; a16 = a[15:0]; b16 = b[15:0]; end
      default: begin s64 = st; c64 = cl; g64 = sg; a64 = a; b64 = b; end
    endcase
  endtask

  function automatic logic get_done(input int w);
    case (w)
      8:       return done8;
      16:      return done16;
      default: return done64;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      8:       return busy8;
      16:      return busy16;
      default: return busy64;
    endcase
  endfunction

  function automatic logic [127:0] get_res(input int w);
    case (w)
      8:       return {112'd0, res8};
      16:      return {96'd0, res16};
      default: return res64;
    endcase
  endfunction

  // Reference: extend to 128 bits, multiply modulo 2^128, keep 2*w bits.
  function automatic logic [127:0] ref_mul(input int w, input logic sg,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [127:0] m, ea, eb, p;
    m  = (128'd1 << w) - 128'd1;
    ea = {64'd0, a} & m;
    eb = {64'd0, b} & m;
    if (sg && ea[w-1]) ea = ea | ~m;
    if (sg && eb[w-1]) eb = eb | ~m;
    p = ea * eb;
    if (w < 64) p = p & ((128'd1 << (2 * w)) - 128'd1);
    return p;
  endfunction

  // One full operation starting at a negedge; returns at the negedge after
  // the DONE->IDLE edge, so a following call issues a back-to-back start.
  task automatic run_op(input int w, input logic sg, input logic [63:0] a,
                        input logic [63:0] b, input logic [127:0] expv, input string tag);
    int steps, n, nbusy;
    bit seen;
    steps = w / 2 + 1;
    n = 0; nbusy = 0; seen = 0;
    drv(w, 1'b1, 1'b0, sg, a, b);
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) drv(w, 1'b0, 1'b0, sg, a, b);
      if (get_busy(w)) nbusy++;
      if (get_done(w)) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s w=%0d timeout: no op_done after %0d cycles", tag, w, n);
      return;
    end
    checks++;
    if (n - 1 !== steps) begin
      errors++;
      $display("FAIL %s w=%0d latency: got %0d edges, want %0d", tag, w, n - 1, steps);
    end
    checks++;
    if (nbusy !== steps + 1) begin
      errors++;
      $display("FAIL %s w=%0d busy_cycles: got %0d, want %0d", tag, w, nbusy, steps + 1);
    end
    checks++;
    if (get_res(w) !== expv) begin
      errors++;
      $display("FAIL %s w=%0d sg=%0b a=%h b=%h result: got %h, want %h", tag, w, sg, a, b, get_res(w), expv);
    end
    @(negedge clk);
    checks++;
    if (get_done(w) !== 1'b0 || get_busy(w) !== 1'b0) begin
      errors++;
      $display("FAIL %s w=%0d after_done: done=%b busy=%b, want 0 0", tag, w, get_done(w), get_busy(w));
    end
    checks++;
    if (get_res(w) !== expv) begin
      errors++;
      $display("FAIL %s w=%0d result_hold: got %h, want %h", tag, w, get_res(w), expv);
    end
  endtask

  task automatic test_reset();
    int ws[3];
    ws = '{8, 16, 64};
    rst = 1'b1;
    foreach (ws[i]) drv(ws[i], 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    foreach (ws[i]) begin
      checks++;
      if (get_busy(ws[i]) !== 1'b0 || get_done(ws[i]) !== 1'b0 || get_res(ws[i]) !== 128'd0) begin
        errors++;
        $display("FAIL reset w=%0d: busy=%b done=%b result=%h, want 0 0 0",
                 ws[i], get_busy(ws[i]), get_done(ws[i]), get_res(ws[i]));
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned8();
    run_op(8, 1'b0, 64'hFF, 64'hFF, 128'hFE01, "u8_ff_ff");
  endtask

  task automatic test_signed8();
    run_op(8, 1'b1, 64'h80, 64'h80, 128'h4000, "s8_80_80");
    run_op(8, 1'b1, 64'hFF, 64'h01, 128'hFFFF, "s8_ff_01");
    run_op(8, 1'b1, 64'h7F, 64'h80, 128'hC080, "s8_7f_80");
  endtask

  task automatic test_w16();
    run_op(16, 1'b0, 64'hFFFF, 64'hFFFF, 128'hFFFE0001, "u16_ffff");
    run_op(16, 1'b1, 64'h8000, 64'h8000, 128'h40000000, "s16_8000");
  endtask

  task automatic test_w64();
    run_op(64, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           128'hFFFFFFFFFFFFFFFE0000000000000001, "u64_ones");
    run_op(64, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           128'h1, "s64_ones");
  endtask

  task automatic test_ignore_restart();
    int n;
    bit seen;
    n = 0; seen = 0;
    drv(8, 1'b1, 1'b0, 1'b0, 64'h12, 64'h34);
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      if (n == 1) drv(8, 1'b0, 1'b0, 1'b0, 64'h12, 64'h34);
      if (n == 2) drv(8, 1'b1, 1'b0, 1'b0, 64'hFF, 64'hFF);
      if (n == 3) drv(8, 1'b0, 1'b0, 1'b0, 64'hFF, 64'hFF);
      if (done8) seen = 1;
    end
    checks++;
    if (!seen || n - 1 !== 5) begin
      errors++;
      $display("FAIL restart_latency: seen=%0b edges=%0d, want 1 5", seen, n - 1);
    end
    checks++;
    if (res8 !== 16'h03A8) begin
      errors++;
      $display("FAIL restart_result: got %h, want 03a8", res8);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || res8 !== 16'h03A8) begin
      errors++;
      $display("FAIL restart_no_queue: busy=%b result=%h, want 0 03a8", busy8, res8);
    end
  endtask

  task automatic test_clear();
    bit seen;
    run_op(8, 1'b0, 64'h03, 64'h05, 128'h000F, "pre_clear");
    drv(8, 1'b1, 1'b0, 1'b0, 64'h12, 64'h34);
    @(negedge clk);
    drv(8, 1'b0, 1'b0, 1'b0, 64'h12, 64'h34);
    @(negedge clk);
    @(negedge clk);
    drv(8, 1'b0, 1'b1, 1'b0, 64'h12, 64'h34);
    @(negedge clk);
    drv(8, 1'b0, 1'b0, 1'b0, 64'h12, 64'h34);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 16'h0000) begin
      errors++;
      $display("FAIL clear_state: busy=%b done=%b result=%h, want 0 0 0000", busy8, done8, res8);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done8) seen = 1;
    end
    checks++;
    if (seen !== 1'b0 || res8 !== 16'h0000) begin
      errors++;
      $display("FAIL clear_no_done: done_seen=%b result=%h, want 0 0000", seen, res8);
    end
    // clear together with start: clear wins
    drv(8, 1'b1, 1'b1, 1'b0, 64'h12, 64'h34);
    @(negedge clk);
    drv(8, 1'b0, 1'b0, 1'b0, 64'h12, 64'h34);
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL clear_beats_start: busy=%b, want 0", busy8);
    end
  endtask

  task automatic test_async_reset();
    run_op(8, 1'b0, 64'h03, 64'h05, 128'h000F, "pre_reset");
    drv(8, 1'b1, 1'b0, 1'b0, 64'hFF, 64'hFF);
    @(negedge clk);
    drv(8, 1'b0, 1'b0, 1'b0, 64'hFF, 64'hFF);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b result=%h, want 0 0 0000", busy8, done8, res8);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(8, 1'b0, 64'h12, 64'h34, 128'h03A8, "post_reset");
  endtask

  task automatic rand_loop(input int w, input int cnt);
    logic [63:0] a, b, m;
    logic sg;
    m = (w < 64) ? ((64'd1 << w) - 64'd1) : 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < cnt; i++) begin
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      sg = 1'($urandom_range(0, 1));
      case (i % 8)
        0: a = '1;
        1: b = '0;
        2: a = 64'd1 << (w - 1);
        3: begin a = 64'd1 << (w - 1); b = a; end
        4: begin a = '1; b = '1; end
        default: ;
      endcase
      a = a & m;
      b = b & m;
      run_op(w, sg, a, b, ref_mul(w, sg, a, b), "rand");
    end
  endtask

  task automatic test_back_to_back();
    fork
      rand_loop(8, 5000);
      rand_loop(16, 3500);
      rand_loop(64, 1500);
    join
  endtask

  initial begin
    test_reset();
    test_unsigned8();
    test_signed8();
    test_w16();
    test_w64();
    test_ignore_restart();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_r4_multiplier.md
Name: booth_r4_multiplier

Overview:
- Parametrised radix-4 (modified Booth) sequential multiplier.
- Successor to the 64-bit radix-2 Booth multiplier: generic WIDTH, a per-operation signed/unsigned mode, two multiplier bits retired per cycle, and a busy flag.
- Sits beside the datapath ALU as a multi-cycle execution unit, driven by the same op_start / op_clear / op_done control protocol.

Parameters:
- WIDTH, 64, operand width in bits; must be even and at least 4.
- STEPS, WIDTH/2+1, number of iteration cycles. Derived; must not be overridden.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- op_start  in  1  start request; sampled only in IDLE
- op_clear  in  1  synchronous abort/clear; highest priority after reset
- op_signed  in  1  1 = two's-complement operands, 0 = unsigned; latched with the operands
- multiplier  in  WIDTH  operand Q
- multiplicand  in  WIDTH  operand M
- op_busy  out  1  high in CALC and DONE
- op_done  out  1  one-cycle completion pulse
- result  out  2*WIDTH  product; held until the next start or clear

Behaviour:
- States: IDLE, CALC, DONE. Encoding is free.
- reset=1 (any time, including mid-operation):
  - state=IDLE
  - all internal registers cleared
  - result=0, op_done=0, op_busy=0
- op_clear=1 at a clock edge: same effect as reset, but synchronous. It wins over a simultaneous op_start and aborts an operation in progress.
- IDLE and op_start=1 at edge E0:
  - Latch M and Q, each extended to WIDTH+2 bits: sign-extended if op_signed=1, zero-extended otherwise.
  - acc (WIDTH+3 bits, signed) = 0; q_1 = 0; step counter = STEPS.
  - Go to CALC.
- op_start outside IDLE is ignored: no restart and no queueing.
- CALC, one step per edge:
  - Booth digit d from {q[1],q[0],q_1}: 000/111 -> 0; 001/010 -> +1; 011 -> +2; 100 -> -2; 101/110 -> -1.
  - acc = acc + d*M, using a sign-extended WIDTH+3-bit add. -M and -2M are formed as two's complement (invert plus carry-in). No overflow is possible at this width.
  - Arithmetic right shift of {acc,q,q_1} by 2.
  - Decrement the counter.
- On the edge where the counter reaches 0 (edge E0+STEPS):
  - result = low 2*WIDTH bits of {acc,q} after the final shift.
  - Go to DONE.
- DONE: op_done=1 for exactly this one cycle; next edge goes to IDLE.
  - A new op_start can be accepted on the edge after DONE, i.e. back-to-back throughput is STEPS+2 cycles.
- Latency: op_done is high in the cycle after edge E0+STEPS (STEPS=33 for WIDTH=64; 5 for WIDTH=8).
- result changes only at the completion edge or on clear/reset. It holds its value through IDLE and through a subsequent CALC until the new result is written.
- Unsigned mode: the product is the exact unsigned 2*WIDTH-bit product. Signed mode: the product is the exact two's-complement 2*WIDTH-bit product. Neither mode wraps or saturates.
- op_busy = (state != IDLE). op_done and op_busy are driven from registered state only; they have no combinational path from inputs.
- Arithmetic is a behavioural adder; a carry-lookahead implementation is permitted but not required.

Test Plan:
- WIDTH=8, op_signed=0, 0xFF*0xFF -> result=0xFE01; op_done pulses exactly once, 5 edges after the start edge; op_busy is high for 6 cycles.
- WIDTH=8, op_signed=1, cover three cases:
  - 0x80*0x80 -> 0x4000
  - 0xFF*0x01 -> 0xFFFF
  - 0x7F*0x80 -> 0xC080
- WIDTH=64, op_signed=0, (2^64-1)*(2^64-1) -> 0xFFFFFFFFFFFFFFFE_0000000000000001. Then op_signed=1 with the same operands -> 0x...0001 (i.e. 1). op_done occurs 33 edges after each start.
- WIDTH=8: start 0x12*0x34, then pulse op_start again on cycle 2 with 0xFF*0xFF -> the second request is ignored; result=0x03A8.
- WIDTH=8: start, then op_clear on cycle 3 -> IDLE next cycle, result=0, no op_done. Also assert reset asynchronously mid-CALC -> outputs are 0 immediately. A fresh start afterwards computes correctly.
- Randomised: 10k random operands and modes at WIDTH=8, 16 and 64, checked against a reference model, including back-to-back starts issued the cycle after DONE.
